bs_turn_ctrl: RTL and testbench
===============================

# bs_turn_ctrl

Game sequencer for the two-board Battleship design. It holds both players' ship maps, grants alternating attack turns, and accumulates each player's attack record over a 4x4 (16-cell) board. It holds each shot result visible for a fixed display interval and declares the winner. It sits between the debounced button/switch front end and the per-board display/attack datapaths; its attack records drive `B_Attack`-style outputs and its load strobes drive the ship registers.

## Interface
Parameters:
- `RES_TICKS`, default 50_000_000: cycles a shot result is held before the turn passes (0.5 s at 100 MHz; benches use small values, minimum 1).
- `CW`, default `$clog2(RES_TICKS+1)`: result-timer width (derived, not overridden).

Ports:
- `clk` in 1: system clock; all state changes on rising edge.
- `clr` in 1: reset, asynchronous, active-high.
- `st` in 1: start, single-cycle strobe.
- `ok_a`, `ok_b` in 1: placement confirmed, level.
- `ships_a`, `ships_b` in 16: ship maps; bit i means a ship occupies cell i.
- `fire_a`, `fire_b` in 1: fire, single-cycle debounced strobe.
- `tgt_a`, `tgt_b` in 4: target cell index.
- `ld_a`, `ld_b` out 1: one-cycle ship-register load strobes.
- `hits_a`, `hits_b` out 16: cells attacked by A (on B's board) and by B (on A's board).
- `turn` out 1: 0 = A to fire, 1 = B to fire.
- `busy` out 1: high in the result-hold states.
- `last_hit` out 1: result of the most recent accepted shot.
- `win_a`, `win_b` out 1: winner flags.
- `state` out 3: current FSM state, for display muxing.

## Operation
- States: IDLE, PLACE, TURN_A, RES_A, TURN_B, RES_B, OVER.
- IDLE: on `st`, go to PLACE and clear `hits_*`, `last_hit` and `win_*`.
- PLACE:
  - When `ok_a && ok_b` and both maps are nonzero: snapshot `ships_a`/`ships_b` into internal registers, pulse `ld_a` and `ld_b` for one cycle, go to TURN_A.
  - A zero map keeps the FSM in PLACE.
- TURN_A:
  - `fire_a` with `hits_a[tgt_a]==0` is accepted. It sets `hits_a[tgt_a]`, sets `last_hit = ship_b_snap[tgt_a]`, loads the timer with `RES_TICKS`, and goes to RES_A.
  - A repeat target (bit already set) is ignored and the FSM stays in TURN_A.
  - `fire_b` is ignored.
- RES_A:
  - The timer decrements each cycle.
  - When the timer reaches 0: if `(hits_a & ship_b_snap) == ship_b_snap`, go to OVER with `win_a=1`; else go to TURN_B.
  - All fire strobes are ignored.
- TURN_B and RES_B mirror TURN_A and RES_A with the roles swapped. RES_B leads to TURN_A or OVER with `win_b=1`.
- OVER:
  - `hits_*` and `win_*` hold.
  - `st` goes to PLACE and clears `hits_*`, `last_hit` and `win_*`.
- `st` in any state other than IDLE and OVER is ignored.
- Live `ships_*` changes after the snapshot have no effect.
- `turn` = 1 in TURN_B/RES_B, else 0.
- `busy` = 1 in RES_A/RES_B.

## Timing
- Reset values: state IDLE; `hits_a`=`hits_b`=16'h0000; `turn`=0; `busy`=0; `last_hit`=0; `win_a`=`win_b`=0; `ld_*`=0; timer 0.
- `clr` mid-game returns the block to IDLE immediately and asynchronously, with all outputs at their reset values.
- Fire acceptance latency: strobe at edge N. `hits_*`, `last_hit`, `busy` and the state update are visible after edge N.
- Result hold: exactly `RES_TICKS` cycles in RES_x. The next turn (or OVER) is visible `RES_TICKS` cycles after entering RES_x.
- `ld_a`/`ld_b` are high for exactly the one cycle after the PLACE→TURN_A transition edge. Snapshot and strobe occur on the same edge.
- Simultaneous `fire_a` and `fire_b` during TURN_A: only `fire_a` is considered.
- A fire strobe held high for multiple cycles produces one acceptance. Later cycles fall in RES_x and are ignored.

## Structure
- Package `bs_pkg` holds:
  - `state_t` enum, 3-bit, encodings IDLE=0 … OVER=6.
  - `CELLS`=16 and `IDXW`=4.
  - `player_t` (A=0, B=1).
- Sub-module `bs_result_timer`: loadable down-counter with a `done` pulse at zero, parameterised by `CW`.

## Test plan
- Reset, then `st`, `ok_a`=`ok_b`=1, `ships_a`=16'h000F, `ships_b`=16'h0003 → `ld_a`/`ld_b` pulse once; state TURN_A; `turn`=0.
- TURN_A, `fire_a`, `tgt_a`=1 → `hits_a`=16'h0002, `last_hit`=1, `busy`=1 for `RES_TICKS`=4 cycles, then TURN_B with `turn`=1.
- TURN_B, `fire_b` at `tgt_b`=9 → `last_hit`=0, `hits_b`=16'h0200. Back in TURN_A, `fire_a` at `tgt_a`=1 again → ignored; state stays TURN_A.
- A fires at cells 0 and 1 across turns → after the second RES_A, state OVER, `win_a`=1, `hits_a`=16'h0003. `st` → PLACE with `hits_*` and `win_*` cleared.
- `ships_b`=0 with `ok_a`=`ok_b`=1 → stays in PLACE, no `ld_*` strobe.
- Assert `clr` during RES_B mid-count → immediate IDLE, all outputs at reset values. Simultaneous `fire_a`+`fire_b` in TURN_A → only `hits_a` changes.

Source files
------------

// File: rtl/bs_pkg.sv
// Shared types and constants for the two-board Battleship sequencer.
package bs_pkg;

    localparam int CELLS = 16;
    localparam int IDXW  = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PLACE  = 3'd1,
        ST_TURN_A = 3'd2,
        ST_RES_A  = 3'd3,
        ST_TURN_B = 3'd4,
        ST_RES_B  = 3'd5,
        ST_OVER   = 3'd6
    } state_t;

    typedef enum logic {
        PLR_A = 1'b0,
        PLR_B = 1'b1
    } player_t;

    // True once every ship cell on the target board has been attacked.
    function automatic logic fleet_sunk(input logic [CELLS-1:0] hits,
                                        input logic [CELLS-1:0] ships);
        return (hits & ships) == ships;
    endfunction

endpackage

// File: rtl/bs_result_timer.sv
// Loadable down-counter that holds a shot result on screen for a fixed time.
module bs_result_timer #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          done
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Raised in the last counting cycle; the count reaches zero on the same edge
    // the controller leaves the hold state.
    assign done = (cnt_q == CW'(1)) && !load;

endmodule

// File: rtl/bs_turn_ctrl.sv
// Battleship turn sequencer: placement, alternating attacks, result hold, winner.
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | after reset, waiting for start
// PLACE   | waiting for both players to confirm nonzero maps
// TURN_A  | player A may fire
// RES_A   | A's shot result held on display
// TURN_B  | player B may fire
// RES_B   | B's shot result held on display
// OVER    | game finished, winner flag held
module bs_turn_ctrl
    import bs_pkg::*;
#(
    parameter int RES_TICKS = 50_000_000,
    parameter int CW        = $clog2(RES_TICKS + 1)
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        st,
    input  logic        ok_a,
    input  logic        ok_b,
    input  logic [15:0] ships_a,
    input  logic [15:0] ships_b,
    input  logic        fire_a,
    input  logic        fire_b,
    input  logic [3:0]  tgt_a,
    input  logic [3:0]  tgt_b,
    output logic        ld_a,
    output logic        ld_b,
    output logic [15:0] hits_a,
    output logic [15:0] hits_b,
    output logic        turn,
    output logic        busy,
    output logic        last_hit,
    output logic        win_a,
    output logic        win_b,
    output logic [2:0]  state
);

    state_t           state_q, state_d;
    logic [CELLS-1:0] hits_a_q, hits_a_d;
    logic [CELLS-1:0] hits_b_q, hits_b_d;
    logic [CELLS-1:0] snap_a_q, snap_a_d;
    logic [CELLS-1:0] snap_b_q, snap_b_d;
    logic             last_hit_q, last_hit_d;
    logic             win_a_q, win_a_d;
    logic             win_b_q, win_b_d;
    logic             ld_q, ld_d;
    logic             tmr_load;
    logic             tmr_done;

    bs_result_timer #(.CW(CW)) u_timer (
        .clk      (clk),
        .clr      (clr),
        .load     (tmr_load),
        .load_val (CW'(RES_TICKS)),
        .done     (tmr_done)
    );

    always_comb begin
        state_d    = state_q;
        hits_a_d   = hits_a_q;
        hits_b_d   = hits_b_q;
        snap_a_d   = snap_a_q;
        snap_b_d   = snap_b_q;
        last_hit_d = last_hit_q;
        win_a_d    = win_a_q;
        win_b_d    = win_b_q;
        ld_d       = 1'b0;
        tmr_load   = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (st) begin
                    state_d    = ST_PLACE;
                    hits_a_d   = '0;
                    hits_b_d   = '0;
                    last_hit_d = 1'b0;
                    win_a_d    = 1'b0;
                    win_b_d    = 1'b0;
                end
            end
            ST_PLACE: begin
                if (ok_a && ok_b && (ships_a != '0) && (ships_b != '0)) begin
                    snap_a_d = ships_a;
                    snap_b_d = ships_b;
                    ld_d     = 1'b1;
                    state_d  = ST_TURN_A;
                end
            end
            ST_TURN_A: begin
                if (fire_a && !hits_a_q[tgt_a]) begin
                    hits_a_d[tgt_a] = 1'b1;
                    last_hit_d      = snap_b_q[tgt_a];
                    tmr_load        = 1'b1;
                    state_d         = ST_RES_A;
                end
            end
            ST_RES_A: begin
                if (tmr_done) begin
                    if (fleet_sunk(hits_a_q, snap_b_q)) begin
                        win_a_d = 1'b1;
                        state_d = ST_OVER;
                    end else begin
                        state_d = ST_TURN_B;
                    end
                end
            end
            ST_TURN_B: begin
                if (fire_b && !hits_b_q[tgt_b]) begin
                    hits_b_d[tgt_b] = 1'b1;
                    last_hit_d      = snap_a_q[tgt_b];
                    tmr_load        = 1'b1;
                    state_d         = ST_RES_B;
                end
            end
            ST_RES_B: begin
                if (tmr_done) begin
                    if (fleet_sunk(hits_b_q, snap_a_q)) begin
                        win_b_d = 1'b1;
                        state_d = ST_OVER;
                    end else begin
                        state_d = ST_TURN_A;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= ST_IDLE;
            hits_a_q   <= '0;
            hits_b_q   <= '0;
            snap_a_q   <= '0;
            snap_b_q   <= '0;
            last_hit_q <= 1'b0;
            win_a_q    <= 1'b0;
            win_b_q    <= 1'b0;
            ld_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            hits_a_q   <= hits_a_d;
            hits_b_q   <= hits_b_d;
            snap_a_q   <= snap_a_d;
            snap_b_q   <= snap_b_d;
            last_hit_q <= last_hit_d;
            win_a_q    <= win_a_d;
            win_b_q    <= win_b_d;
            ld_q       <= ld_d;
        end
    end

    assign ld_a     = ld_q;
    assign ld_b     = ld_q;
    assign hits_a   = hits_a_q;
    assign hits_b   = hits_b_q;
    assign last_hit = last_hit_q;
    assign win_a    = win_a_q;
    assign win_b    = win_b_q;
    assign state    = state_q;
    assign busy     = (state_q == ST_RES_A) || (state_q == ST_RES_B);
    assign turn     = ((state_q == ST_TURN_B) || (state_q == ST_RES_B)) ? PLR_B : PLR_A;

endmodule

// File: tb/tb_bs_turn_ctrl.sv
// Self-checking bench for bs_turn_ctrl: directed vectors, corner sequences, random games.
module tb_bs_turn_ctrl;

    localparam int R = 4;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PLACE  = 3'd1;
    localparam logic [2:0] S_TURN_A = 3'd2;
    localparam logic [2:0] S_RES_A  = 3'd3;
    localparam logic [2:0] S_TURN_B = 3'd4;
    localparam logic [2:0] S_RES_B  = 3'd5;
    localparam logic [2:0] S_OVER   = 3'd6;

    logic        clk = 1'b0;
    logic        clr, st, ok_a, ok_b, fire_a, fire_b;
    logic [15:0] ships_a, ships_b;
    logic [3:0]  tgt_a, tgt_b;
    logic        ld_a, ld_b, turn, busy, last_hit, win_a, win_b;
    logic [15:0] hits_a, hits_b;
    logic [2:0]  state;

    int passed = 0;
    int total  = 0;

    bs_turn_ctrl #(.RES_TICKS(R)) dut (
        .clk(clk), .clr(clr), .st(st), .ok_a(ok_a), .ok_b(ok_b),
        .ships_a(ships_a), .ships_b(ships_b),
        .fire_a(fire_a), .fire_b(fire_b), .tgt_a(tgt_a), .tgt_b(tgt_b),
        .ld_a(ld_a), .ld_b(ld_b), .hits_a(hits_a), .hits_b(hits_b),
        .turn(turn), .busy(busy), .last_hit(last_hit),
        .win_a(win_a), .win_b(win_b), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic shoot(input logic fa, input logic fb, input logic [3:0] ta, input logic [3:0] tb);
        fire_a = fa; fire_b = fb; tgt_a = ta; tgt_b = tb;
        step();
        fire_a = 1'b0; fire_b = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_state"}, state, S_IDLE);
        chk({tag, "_hits"}, {hits_a, hits_b}, 32'h0);
        chk({tag, "_flags"}, {turn, busy, last_hit, win_a, win_b, ld_a, ld_b}, 7'b0);
    endtask

    // Restart into TURN_A with the given maps, starting from IDLE or OVER.
    task automatic start_game(input logic [15:0] sa, input logic [15:0] sb);
        ships_a = sa; ships_b = sb; ok_a = 1'b1; ok_b = 1'b1;
        st = 1'b1; step(); st = 1'b0;
        step();
    endtask

    typedef struct {
        logic        fa, fb;
        logic [3:0]  ta, tb;
        logic        acc;
        logic [2:0]  st_now;
        logic [15:0] ha, hb;
        logic        lh;
        logic [2:0]  st_after;
        logic        wa, wb;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{fa:1, fb:1, ta:1, tb:5, acc:1, st_now:S_RES_A, ha:16'h0002, hb:16'h0000,
                    lh:1, st_after:S_TURN_B, wa:0, wb:0};
        vecs[1] = '{fa:0, fb:1, ta:0, tb:9, acc:1, st_now:S_RES_B, ha:16'h0002, hb:16'h0200,
                    lh:0, st_after:S_TURN_A, wa:0, wb:0};
        vecs[2] = '{fa:1, fb:0, ta:1, tb:0, acc:0, st_now:S_TURN_A, ha:16'h0002, hb:16'h0200,
                    lh:0, st_after:S_TURN_A, wa:0, wb:0};
        vecs[3] = '{fa:1, fb:0, ta:0, tb:0, acc:1, st_now:S_RES_A, ha:16'h0003, hb:16'h0200,
                    lh:1, st_after:S_OVER, wa:1, wb:0};

        clr = 1'b1; st = 1'b0; ok_a = 1'b0; ok_b = 1'b0;
        ships_a = '0; ships_b = '0; fire_a = 1'b0; fire_b = 1'b0; tgt_a = '0; tgt_b = '0;
        #3;
        chk_reset_outputs("reset");
        step(); step();
        clr = 1'b0;
        step();
        chk_reset_outputs("post_reset");

        st = 1'b1; step(); st = 1'b0;
        chk("start_state", state, S_PLACE);

        // Zero map for B keeps placement open.
        ships_a = 16'h000F; ships_b = 16'h0000; ok_a = 1'b1; ok_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("zero_map_state", state, S_PLACE);
            chk("zero_map_ld", {ld_a, ld_b}, 2'b00);
        end

        ships_b = 16'h0003;
        step();
        chk("place_state", state, S_TURN_A);
        chk("place_ld", {ld_a, ld_b}, 2'b11);
        chk("place_turn", turn, 1'b0);
        ships_b = 16'hFFFF;  // after snapshot, must not matter
        step();
        chk("ld_one_cycle", {ld_a, ld_b}, 2'b00);

        foreach (vecs[k]) begin
            shoot(vecs[k].fa, vecs[k].fb, vecs[k].ta, vecs[k].tb);
            chk($sformatf("v%0d_state", k), state, vecs[k].st_now);
            chk($sformatf("v%0d_hits", k), {hits_a, hits_b}, {vecs[k].ha, vecs[k].hb});
            chk($sformatf("v%0d_last", k), last_hit, vecs[k].lh);
            chk($sformatf("v%0d_busy", k), busy, vecs[k].acc);
            if (vecs[k].acc) begin
                for (int c = 1; c < R; c++) begin
                    step();
                    chk($sformatf("v%0d_hold", k), {busy, state}, {1'b1, vecs[k].st_now});
                end
                step();
                chk($sformatf("v%0d_after", k), state, vecs[k].st_after);
                chk($sformatf("v%0d_busy_end", k), busy, 1'b0);
                chk($sformatf("v%0d_turn", k), turn, vecs[k].st_after == S_TURN_B);
                chk($sformatf("v%0d_win", k), {win_a, win_b}, {vecs[k].wa, vecs[k].wb});
            end
        end

        step(); step();
        chk("over_hold", {state, win_a, hits_a}, {S_OVER, 1'b1, 16'h0003});
        ships_b = 16'h0003;
        st = 1'b1; step(); st = 1'b0;
        chk("restart_state", state, S_PLACE);
        chk("restart_clear", {hits_a, hits_b, win_a, win_b, last_hit}, 35'h0);

        // Game 2: clr while B's result is held.
        step();
        chk("g2_turn_a", state, S_TURN_A);
        shoot(1'b1, 1'b0, 4'd7, 4'd0);
        repeat (R) step();
        chk("g2_turn_b", state, S_TURN_B);
        shoot(1'b0, 1'b1, 4'd2, 4'd0);
        chk("g2_res_b", {state, last_hit}, {S_RES_B, 1'b1});
        step();
        #2 clr = 1'b1;
        #1;
        chk_reset_outputs("clr_mid");
        step();
        clr = 1'b0;
        step();
        chk("clr_stays_idle", state, S_IDLE);

        // Fire held for several cycles produces exactly one acceptance.
        start_game(16'h00F0, 16'h0011);
        chk("g3_turn_a", state, S_TURN_A);
        fire_a = 1'b1; tgt_a = 4'd4;
        for (int c = 0; c < R + 3; c++) step();
        tgt_a = 4'd5;
        step();
        fire_a = 1'b0;
        chk("held_fire_hits", hits_a, 16'h0010);
        chk("held_fire_state", state, S_TURN_B);
        st = 1'b1; step(); st = 1'b0;
        chk("st_ignored", state, S_TURN_B);

        // Random games against a shot-level reference model.
        for (int g = 0; g < 6; g++) begin
            logic [15:0] sa, sb, mha, mhb;
            logic        p, over, won, acc;
            logic [3:0]  t;
            sa = 16'($urandom()) & 16'($urandom());
            sb = 16'($urandom()) & 16'($urandom());
            if (sa == 0) sa = 16'h8000;
            if (sb == 0) sb = 16'h0001;
            clr = 1'b1; #1 clr = 1'b0;
            start_game(sa, sb);
            chk("rg_start", state, S_TURN_A);
            ships_a = 16'($urandom()); ships_b = 16'($urandom());
            mha = '0; mhb = '0; p = 1'b0; over = 1'b0;
            for (int n = 0; n < 400 && !over; n++) begin
                if ($urandom_range(0, 3) == 0) begin
                    st = 1'b1; step(); st = 1'b0;
                    chk("rg_idle_st", state, p ? S_TURN_B : S_TURN_A);
                end
                t = 4'($urandom_range(0, 15));
                if (!p) shoot(1'b1, 1'($urandom_range(0, 1)), t, 4'($urandom_range(0, 15)));
                else    shoot(1'($urandom_range(0, 1)), 1'b1, 4'($urandom_range(0, 15)), t);
                acc = p ? !mhb[t] : !mha[t];
                if (acc) begin
                    if (!p) mha[t] = 1'b1; else mhb[t] = 1'b1;
                    chk("rg_last", last_hit, p ? sa[t] : sb[t]);
                    chk("rg_state", state, p ? S_RES_B : S_RES_A);
                end else begin
                    chk("rg_repeat", state, p ? S_TURN_B : S_TURN_A);
                end
                chk("rg_hits", {hits_a, hits_b}, {mha, mhb});
                if (acc) begin
                    repeat (R - 1) step();
                    chk("rg_busy", busy, 1'b1);
                    step();
                    won = p ? ((mhb & sa) == sa) : ((mha & sb) == sb);
                    if (won) begin
                        over = 1'b1;
                        chk("rg_over", {state, win_a, win_b}, {S_OVER, !p, p});
                    end else begin
                        p = !p;
                        chk("rg_next", {state, win_a, win_b}, {p ? S_TURN_B : S_TURN_A, 2'b00});
                    end
                end
            end
            chk("rg_game_ended", over, 1'b1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
